// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: pipeline control for the 5-stage CPU front end.
//
// Owns the PC register and the IF/ID pipeline register. Consumes the load-use
// stall request and the branch-taken (flush) request, and drives the ID/EX
// bubble and EX/MEM flush strobes combinationally for the current edge.
// Also tracks the RUN/STALL/FLUSH control state, a sticky stuck-stall
// watchdog and (optionally) saturating stall/flush performance counters.
//
// Build option: define PIPE_STAGE_CTRL_PERF_EN to implement the performance
// counters; when undefined, stall_cnt_o and flush_cnt_o are tied to zero.
//
// Ports:
//   clk_i            clock, all state updates on rising edge
//   rst_i            synchronous active-high reset
//   hazard_i         load-use stall request
//   branch_taken_i   branch resolved taken in MEM this cycle
//   branch_target_i  branch target PC, valid with branch_taken_i
//   imem_instr_i     instruction memory data at address pc_o
//   pc_o             current PC
//   ifid_instr_o     IF/ID instruction (0 = NOP)
//   ifid_pc4_o       IF/ID PC+4
//   ifid_valid_o     IF/ID holds a real instruction
//   idex_bubble_o    ID/EX loads zero control bits this edge
//   exmem_flush_o    EX/MEM loads zero control bits this edge
//   state_o          action taken at previous edge: 0=RUN, 1=STALL, 2=FLUSH
//   stall_err_o      sticky watchdog error
//   stall_cnt_o      total stall cycles (saturating)
//   flush_cnt_o      total taken-branch flushes (saturating)

module pipe_stage_ctrl #(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter int unsigned          MAX_STALL = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hazard_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [PC_W-1:0]    ifid_pc4_o,
    output logic               ifid_valid_o,
    output logic               idex_bubble_o,
    output logic               exmem_flush_o,
    output logic [1:0]         state_o,
    output logic               stall_err_o,
    output logic [15:0]        stall_cnt_o,
    output logic [15:0]        flush_cnt_o
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic [3:0] MaxStall = 4'(MAX_STALL);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc4_q, ifid_pc4_d;
    logic               ifid_valid_q, ifid_valid_d;
    state_e             state_q, state_d;
    logic [3:0]         stall_run_q, stall_run_d;
    logic               stall_err_q, stall_err_d;

    logic               stall_eff;
    logic [PC_W-1:0]    pc_plus4;

    // A bubble sitting in IF/ID has no consumer to protect, so it never stalls.
    assign stall_eff = hazard_i & ifid_valid_q;
    assign pc_plus4  = pc_q + PC_W'(4);

    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        state_d      = state_q;
        stall_run_d  = stall_run_q;

        if (branch_taken_i) begin
            // Flush wins over any simultaneous hazard.
            pc_d         = branch_target_i;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
            state_d      = StFlush;
            stall_run_d  = '0;
        end else if (stall_eff) begin
            state_d = StStall;
            // Saturate so a very long stall cannot wrap below the threshold.
            if (stall_run_q != 4'hF) begin
                stall_run_d = stall_run_q + 4'd1;
            end
        end else begin
            pc_d         = pc_plus4;
            ifid_instr_d = imem_instr_i;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            state_d      = StRun;
            stall_run_d  = '0;
        end

        stall_err_d = stall_err_q | (stall_run_d >= MaxStall);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            state_q      <= StRun;
            stall_run_q  <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            state_q      <= state_d;
            stall_run_q  <= stall_run_d;
            stall_err_q  <= stall_err_d;
        end
    end

`ifdef PIPE_STAGE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (branch_taken_i) begin
            if (flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end else if (stall_eff) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

    // Strobes are suppressed during reset so downstream registers see no action.
    assign idex_bubble_o = ~rst_i & (branch_taken_i | stall_eff);
    assign exmem_flush_o = ~rst_i & branch_taken_i;

    assign pc_o         = pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_valid_o = ifid_valid_q;
    assign state_o      = state_q;
    assign stall_err_o  = stall_err_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed testbench for pipe_stage_ctrl. Two instances share stimulus:
// dut_a uses RESET_PC=0x100, dut_b uses RESET_PC=0xFFFFFFFC for PC wrap.

module tb_pipe_stage_ctrl;

`ifdef PIPE_STAGE_CTRL_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        branch;
    logic [31:0] target;
    logic [31:0] imem;

    logic [31:0] pc_a, instr_a, pc4_a;
    logic        valid_a, bubble_a, flush_a, err_a;
    logic [1:0]  state_a;
    logic [15:0] scnt_a, fcnt_a;

    logic [31:0] pc_b, instr_b, pc4_b;
    logic        valid_b, bubble_b, flush_b, err_b;
    logic [1:0]  state_b;
    logic [15:0] scnt_b, fcnt_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(
        .PC_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0100), .MAX_STALL(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .hazard_i(hazard), .branch_taken_i(branch),
        .branch_target_i(target), .imem_instr_i(imem), .pc_o(pc_a),
        .ifid_instr_o(instr_a), .ifid_pc4_o(pc4_a), .ifid_valid_o(valid_a),
        .idex_bubble_o(bubble_a), .exmem_flush_o(flush_a), .state_o(state_a),
        .stall_err_o(err_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
    );

    pipe_stage_ctrl #(
        .PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC), .MAX_STALL(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .hazard_i(hazard), .branch_taken_i(branch),
        .branch_target_i(target), .imem_instr_i(imem), .pc_o(pc_b),
        .ifid_instr_o(instr_b), .ifid_pc4_o(pc4_b), .ifid_valid_o(valid_b),
        .idex_bubble_o(bubble_b), .exmem_flush_o(flush_b), .state_o(state_b),
        .stall_err_o(err_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int n);
        return PerfEn ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered IF/ID and control view of dut_a.
    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic [1:0] st);
        chk({tag, ".pc"}, pc_a, pc);
        chk({tag, ".instr"}, instr_a, instr);
        chk({tag, ".pc4"}, pc4_a, pc4);
        chk({tag, ".valid"}, 32'(valid_a), 32'(valid));
        chk({tag, ".state"}, 32'(state_a), 32'(st));
    endtask

    task automatic chk_strobes(input string tag, input logic bub, input logic fl);
        #1;
        chk({tag, ".bubble"}, 32'(bubble_a), 32'(bub));
        chk({tag, ".flush"}, 32'(flush_a), 32'(fl));
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b1; branch = 1'b1; target = 32'h0000_0800; imem = 32'h0;
        chk_strobes("rst_forced", 1'b0, 1'b0);
        chk("rst_forced_b.bubble", 32'(bubble_b), 32'd0);
        tick();
        hazard = 1'b0; branch = 1'b0;
        tick();
        chk_a("reset", 32'h100, 32'h0, 32'h0, 1'b0, 2'd0);
        chk("reset.err", 32'(err_a), 32'd0);
        chk("reset.scnt", 32'(scnt_a), 32'd0);
        chk("reset.fcnt", 32'(fcnt_a), 32'd0);
        chk("reset_b.pc", pc_b, 32'hFFFF_FFFC);

        // Three RUN cycles.
        rst = 1'b0; imem = 32'h1111_1111;
        chk_strobes("run1", 1'b0, 1'b0);
        tick();
        chk_a("run1", 32'h104, 32'h1111_1111, 32'h104, 1'b1, 2'd0);
        chk("wrap_b.pc", pc_b, 32'h0);
        chk("wrap_b.pc4", pc4_b, 32'h0);
        chk("wrap_b.instr", instr_b, 32'h1111_1111);
        chk("wrap_b.valid", 32'(valid_b), 32'd1);
        chk("wrap_b.misc", {state_b, err_b, flush_b, scnt_b, fcnt_b}, 32'h0);
        imem = 32'h2222_2222;
        tick();
        chk("run2.pc", pc_a, 32'h108);
        imem = 32'h3333_3333;
        tick();
        chk_a("run3", 32'h10C, 32'h3333_3333, 32'h10C, 1'b1, 2'd0);

        // Flush to 0x1FC.
        branch = 1'b1; target = 32'h0000_01FC;
        chk_strobes("br1", 1'b1, 1'b1);
        tick();
        chk_a("br1", 32'h1FC, 32'h0, 32'h0, 1'b0, 2'd2);
        chk("br1.fcnt", 32'(fcnt_a), cnt(1));

        // Hazard with invalid IF/ID: must run, not stall.
        branch = 1'b0; hazard = 1'b1; imem = 32'hAAAA_0001;
        chk_strobes("hz_inv", 1'b0, 1'b0);
        tick();
        chk_a("hz_inv", 32'h200, 32'hAAAA_0001, 32'h200, 1'b1, 2'd0);
        chk("hz_inv.scnt", 32'(scnt_a), cnt(0));

        // One-cycle stall at pc 0x200.
        imem = 32'hBBBB_0002;
        chk_strobes("stall1", 1'b1, 1'b0);
        tick();
        chk_a("stall1", 32'h200, 32'hAAAA_0001, 32'h200, 1'b1, 2'd1);
        chk("stall1.scnt", 32'(scnt_a), cnt(1));
        hazard = 1'b0;
        chk_strobes("unstall", 1'b0, 1'b0);
        tick();
        chk_a("unstall", 32'h204, 32'hBBBB_0002, 32'h204, 1'b1, 2'd0);

        // Branch with simultaneous hazard: flush wins.
        branch = 1'b1; hazard = 1'b1; target = 32'h0000_0400;
        chk_strobes("br2", 1'b1, 1'b1);
        tick();
        chk_a("br2", 32'h400, 32'h0, 32'h0, 1'b0, 2'd2);
        chk("br2.fcnt", 32'(fcnt_a), cnt(2));
        chk("br2.scnt", 32'(scnt_a), cnt(1));
        branch = 1'b0; imem = 32'hCCCC_0003;
        chk_strobes("br2_next", 1'b0, 1'b0);
        tick();
        chk_a("br2_next", 32'h404, 32'hCCCC_0003, 32'h404, 1'b1, 2'd0);
        chk("br2_next.scnt", 32'(scnt_a), cnt(1));

        // Watchdog: hazard held for 4 edges.
        tick(); tick(); tick();
        chk("wd3.err", 32'(err_a), 32'd0);
        chk("wd3.state", 32'(state_a), 32'd1);
        chk("wd3.pc", pc_a, 32'h404);
        tick();
        chk("wd4.err", 32'(err_a), 32'd1);
        chk("wd4.scnt", 32'(scnt_a), cnt(5));
        hazard = 1'b0;
        tick();
        chk("wd_drop.err", 32'(err_a), 32'd1);
        chk_a("wd_drop", 32'h408, 32'hCCCC_0003, 32'h408, 1'b1, 2'd0);
        tick();
        chk("wd_hold.err", 32'(err_a), 32'd1);

        // Reset during a stall at pc 0x300.
        branch = 1'b1; target = 32'h0000_02FC;
        tick();
        branch = 1'b0; imem = 32'hDDDD_0004;
        tick();
        chk("pre_rst.pc", pc_a, 32'h300);
        hazard = 1'b1;
        tick();
        chk("mid_stall.state", 32'(state_a), 32'd1);
        chk("mid_stall.pc", pc_a, 32'h300);
        rst = 1'b1;
        chk_strobes("rst_stall", 1'b0, 1'b0);
        tick();
        chk_a("rst_stall", 32'h100, 32'h0, 32'h0, 1'b0, 2'd0);
        chk("rst_stall.err", 32'(err_a), 32'd0);
        chk("rst_stall.scnt", 32'(scnt_a), 32'd0);
        chk("rst_stall.fcnt", 32'(fcnt_a), 32'd0);
        rst = 1'b0; hazard = 1'b0; imem = 32'hEEEE_0005;
        tick();
        chk_a("restart", 32'h104, 32'hEEEE_0005, 32'h104, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Consumer of the load-use stall and branch-flush requests from hazard detection in the 5-stage pipelined CPU.
- Owns the PC register and the IF/ID pipeline register; drives the bubble/flush strobes for the ID/EX and EX/MEM registers.
- Tracks pipeline control state (RUN/STALL/FLUSH), a stuck-stall watchdog and performance counters.
- Sits between the instruction memory and the decode stage.

Parameters:
PC_W, 32, width of PC and PC+4 values
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
MAX_STALL, 4, consecutive stall cycles that trip the watchdog (range 1..15)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
hazard_i  in  1  load-use stall request (1 = stall)
branch_taken_i  in  1  branch resolved taken in MEM this cycle
branch_target_i  in  PC_W  target PC, valid with branch_taken_i
imem_instr_i  in  INSTR_W  instruction memory data at address pc_o (combinational read)
pc_o  out  PC_W  current PC register
ifid_instr_o  out  INSTR_W  IF/ID instruction
ifid_pc4_o  out  PC_W  IF/ID PC+4
ifid_valid_o  out  1  IF/ID holds a real instruction
idex_bubble_o  out  1  comb: ID/EX must load zero control bits this edge
exmem_flush_o  out  1  comb: EX/MEM must load zero control bits this edge
state_o  out  2  0=RUN, 1=STALL, 2=FLUSH (3 unused)
stall_err_o  out  1  sticky watchdog error
stall_cnt_o  out  16  total stall cycles
flush_cnt_o  out  16  total taken-branch flushes

Behaviour:
- Reset (rst_i=1 at edge):
  - pc_o=RESET_PC; ifid_instr_o=0 (NOP); ifid_pc4_o=0; ifid_valid_o=0.
  - state_o=RUN; stall_err_o=0; counters=0; internal stall run counter=0.
- While rst_i=1, idex_bubble_o and exmem_flush_o are forced to 0.
- Effective stall: stall_eff = hazard_i & ifid_valid_o. A bubble in IF/ID never stalls.
- Per-cycle action, in priority order:
  1. branch_taken_i=1 (FLUSH):
     - pc_o<=branch_target_i; ifid_instr_o<=0; ifid_pc4_o<=0; ifid_valid_o<=0.
     - idex_bubble_o=1 and exmem_flush_o=1 in the same cycle.
     - state_o<=FLUSH; flush_cnt_o++; stall run counter<=0.
     - A simultaneous hazard_i is ignored and does not count as a stall.
  2. stall_eff=1 (STALL):
     - pc_o and all IF/ID fields hold; idex_bubble_o=1; exmem_flush_o=0.
     - state_o<=STALL; stall_cnt_o++; stall run counter++.
  3. Otherwise (RUN):
     - pc_o<=pc_o+4; ifid_instr_o<=imem_instr_i; ifid_pc4_o<=pc_o+4; ifid_valid_o<=1.
     - Strobes 0; state_o<=RUN; stall run counter<=0.
- state_o reflects the action taken at the previous edge. Every action is legal from every state, so there are no illegal transitions. Unused encoding 3 behaves as RUN.
- PC+4 wraps modulo 2^PC_W, e.g. PC_W=32: 0xFFFFFFFC -> 0x00000000. No alignment check on branch_target_i.
- Latency:
  - Fetched instruction appears on ifid_instr_o one cycle after pc_o addresses it.
  - Branch target appears on pc_o one cycle after branch_taken_i.
  - First valid IF/ID after a flush is two cycles after branch_taken_i.
- Watchdog: when the stall run counter reaches MAX_STALL, stall_err_o<=1. It stays 1 until reset and does not alter pipeline control.
- Counters saturate at 0xFFFF.
- Reset mid-stall or mid-flush discards all state; the pipeline restarts at RESET_PC.

Optional Feature:
- Macro PIPE_STAGE_CTRL_PERF_EN.
- Defined: stall_cnt_o and flush_cnt_o implemented as above.
- Undefined: counter registers absent; stall_cnt_o and flush_cnt_o tied to 0. All other behaviour unchanged, including the watchdog.

Test Plan:
- Reset with RESET_PC=0x100, then 3 idle cycles with imem=0x11111111,0x22222222,0x33333333:
  - pc_o goes 0x100->0x104->0x108->0x10C.
  - ifid_instr_o ends at 0x33333333 with ifid_pc4_o=0x10C and ifid_valid_o=1.
- From RUN at pc_o=0x200, hazard_i=1 for 1 cycle:
  - idex_bubble_o=1 that cycle; pc_o stays 0x200 and IF/ID holds.
  - state_o=STALL for 1 cycle, then RUN; stall_cnt_o=1.
- branch_taken_i=1 with target 0x400 and hazard_i=1 simultaneously:
  - idex_bubble_o=1 and exmem_flush_o=1.
  - Next cycle pc_o=0x400, ifid_valid_o=0, state_o=FLUSH; flush_cnt_o=1, stall_cnt_o unchanged.
  - hazard_i=1 on the following cycle causes no stall (IF/ID invalid).
- hazard_i=1 held 4 cycles with MAX_STALL=4:
  - stall_err_o rises after the 4th edge.
  - It stays 1 after hazard_i drops; only rst_i clears it.
- PC_W=32, RESET_PC=0xFFFFFFFC, one RUN cycle:
  - pc_o=0x00000000, ifid_pc4_o=0x00000000.
- Assert rst_i during STALL with pc_o=0x300:
  - Next edge gives pc_o=RESET_PC, state_o=RUN, counters 0.
  - With the macro undefined, the counters read 0 throughout.
